final_result_buffer: RTL and testbench

Capture buffer on the result side of FINAL_Top. Samples each Done_t/Result pair the core emits after a Go, stores the results in order in a 64-entry buffer, and signals when the expected number has arrived. The host reads results back over a 6-bit address / 32-bit data port that mirrors the M_* load port, which closes the load → run → collect loop.

---
 rtl/final_result_buffer.sv | 124 ++++++++++++
 tb/tb_final_result_buffer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/final_result_buffer.sv
// rtl/final_result_buffer.sv - result capture buffer with host read port; optional running checksum under FINAL_RB_CHECKSUM_EN
module final_result_buffer #(
  parameter int R_WIDTH    = 20,
  parameter int ADDR_WIDTH = 6,
  parameter int ITR        = 64
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Go_t,
  input  logic                  Done_t,
  input  logic [R_WIDTH-1:0]    Result,
  input  logic                  R_enb,
  input  logic [ADDR_WIDTH-1:0] R_Addr6,
  output logic [31:0]           R_do32,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Busy,
  output logic                  Full,
  output logic                  Ovf
`ifdef FINAL_RB_CHECKSUM_EN
  ,
  output logic [R_WIDTH+ADDR_WIDTH-1:0] Chk
`endif
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ITR_C = CNT_W'(ITR);
  localparam logic [ADDR_WIDTH:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [ADDR_WIDTH:0] count_inc;
  logic                ovf_q, ovf_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                wr_en;
  logic [R_WIDTH-1:0]  mem_q [DEPTH];

`ifdef FINAL_RB_CHECKSUM_EN
  localparam int CW = R_WIDTH + ADDR_WIDTH;
  logic [CW-1:0] chk_q, chk_d;
`endif

  assign count_inc = count_q + ONE_C;

  // Next-state logic: Go_t restarts from any state and wins over a same-cycle Done_t
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    if (Go_t) begin
      state_d = S_ARMED;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARMED: begin
          if (Done_t) begin
            wr_en   = 1'b1;
            count_d = count_inc;
            if (count_inc == ITR_C) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (Done_t) ovf_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Host read: registered, holds when not enabled, sees pre-write content
  always_comb begin
    rdata_d = rdata_q;
    if (R_enb) rdata_d = 32'(mem_q[R_Addr6]);
  end

`ifdef FINAL_RB_CHECKSUM_EN
  // Running sum of captured results; dropped and overflow samples never reach wr_en
  always_comb begin
    chk_d = chk_q;
    if (Go_t) chk_d = '0;
    else if (wr_en) chk_d = chk_q + CW'(Result);
  end

  // Checksum register
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) chk_q <= '0;
    else     chk_q <= chk_d;
  end

  assign Chk = chk_q;
`endif

  // Control and read-data registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      ovf_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      rdata_q <= rdata_d;
    end
  end

  // Result storage, not reset; written at the current count position
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[count_q[ADDR_WIDTH-1:0]] <= Result;
  end

  assign R_do32 = rdata_q;
  assign Count  = count_q;
  assign Busy   = (state_q == S_ARMED);
  assign Full   = (state_q == S_DONE);
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_final_result_buffer.sv
// tb/tb_final_result_buffer.sv - directed self-checking bench for final_result_buffer
module tb_final_result_buffer;

  logic        clk;
  logic        rst;
  logic        go;
  logic        done;
  logic [19:0] result;
  logic        r_enb;
  logic [5:0]  r_addr;
  logic [31:0] r_do32;
  logic [6:0]  count;
  logic        busy;
  logic        full;
  logic        ovf;
`ifdef FINAL_RB_CHECKSUM_EN
  logic [25:0] chk;
`endif

  int checks = 0;
  int errors = 0;

  final_result_buffer #(.R_WIDTH(20), .ADDR_WIDTH(6), .ITR(64)) dut (
    .Clk(clk), .Rst(rst), .Go_t(go), .Done_t(done), .Result(result),
    .R_enb(r_enb), .R_Addr6(r_addr), .R_do32(r_do32), .Count(count),
    .Busy(busy), .Full(full), .Ovf(ovf)
`ifdef FINAL_RB_CHECKSUM_EN
    , .Chk(chk)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (r_do32 !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", r_do32); end
  endtask

  task automatic test_spaced();
    pulse_go();
    checks++; if (busy !== 1'b1 || count !== 7'd0) begin errors++; $display("FAIL spaced_arm busy %b count %0d want 1/0", busy, count); end
    for (int i = 0; i < 64; i++) begin
      done = 1'b1; result = 20'(i * 3 + 1);
      tick();
      done = 1'b0;
      tick(); tick();
    end
    checks++; if (count !== 7'd64) begin errors++; $display("FAIL spaced_count got %0d want 64", count); end
    checks++; if (full !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL spaced_flags full %b busy %b want 1/0", full, busy); end
    for (int a = 0; a < 64; a++) begin
      r_enb = 1'b1; r_addr = 6'(a);
      tick();
      checks++; if (r_do32 !== 32'(a * 3 + 1)) begin errors++; $display("FAIL spaced_read addr %0d got %h want %h", a, r_do32, 32'(a * 3 + 1)); end
    end
    r_addr = 6'd5;
    tick();
    checks++; if (r_do32 !== 32'h0000_0010) begin errors++; $display("FAIL spaced_addr5 got %h want 00000010", r_do32); end
    r_enb = 1'b0; r_addr = 6'd9;
    tick();
    checks++; if (r_do32 !== 32'h0000_0010) begin errors++; $display("FAIL read_hold got %h want 00000010", r_do32); end
  endtask

  task automatic test_back_to_back();
    pulse_go();
    for (int i = 0; i < 64; i++) begin
      done = 1'b1; result = 20'hFFFFF - 20'(i);
      tick();
      if (i == 62) begin
        checks++; if (count !== 7'd63 || full !== 1'b0) begin errors++; $display("FAIL b2b_63 count %0d full %b want 63/0", count, full); end
      end
    end
    done = 1'b0;
    checks++; if (count !== 7'd64 || full !== 1'b1) begin errors++; $display("FAIL b2b_64 count %0d full %b want 64/1", count, full); end
    r_enb = 1'b1; r_addr = 6'd63;
    tick();
    checks++; if (r_do32 !== 32'h000F_FFC0) begin errors++; $display("FAIL b2b_addr63 got %h want 000FFFC0", r_do32); end
    r_addr = 6'd0;
    tick();
    r_enb = 1'b0;
    checks++; if (r_do32 !== 32'h000F_FFFF) begin errors++; $display("FAIL b2b_addr0 got %h want 000FFFFF", r_do32); end
  endtask

  task automatic test_overflow();
    done = 1'b1; result = 20'h12345;
    tick();
    done = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    checks++; if (count !== 7'd64 || full !== 1'b1) begin errors++; $display("FAIL ovf_count count %0d full %b want 64/1", count, full); end
    r_enb = 1'b1; r_addr = 6'd0;
    tick();
    checks++; if (r_do32 !== 32'h000F_FFFF) begin errors++; $display("FAIL ovf_buf0 got %h want 000FFFFF", r_do32); end
    r_enb = 1'b0;
    tick();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    pulse_go();
    checks++; if (ovf !== 1'b0 || full !== 1'b0 || count !== 7'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL ovf_clear ovf %b full %b count %0d busy %b want 0/0/0/1", ovf, full, count, busy);
    end
  endtask

  task automatic test_go_drop();
    pulse_go();
    for (int i = 0; i < 19; i++) begin
      done = 1'b1; result = 20'(256 + i);
      tick();
    end
    checks++; if (count !== 7'd19) begin errors++; $display("FAIL drop_pre count got %0d want 19", count); end
    go = 1'b1; result = 20'h55555;
    tick();
    go = 1'b0; done = 1'b0;
    checks++; if (count !== 7'd0 || busy !== 1'b1) begin errors++; $display("FAIL drop_restart count %0d busy %b want 0/1", count, busy); end
    done = 1'b1; result = 20'hABCDE;
    tick();
    done = 1'b0;
    checks++; if (count !== 7'd1) begin errors++; $display("FAIL drop_next count got %0d want 1", count); end
    r_enb = 1'b1; r_addr = 6'd0;
    tick();
    checks++; if (r_do32 !== 32'h000A_BCDE) begin errors++; $display("FAIL drop_addr0 got %h want 000ABCDE", r_do32); end
    r_addr = 6'd19;
    tick();
    r_enb = 1'b0;
    checks++; if (r_do32 !== 32'h000F_FFEC) begin errors++; $display("FAIL drop_addr19 got %h want 000FFFEC", r_do32); end
  endtask

  task automatic test_rst_midrun();
    pulse_go();
    for (int i = 0; i < 10; i++) begin
      done = 1'b1; result = 20'(512 + i);
      tick();
    end
    done = 1'b0;
    checks++; if (count !== 7'd10) begin errors++; $display("FAIL rst_pre count got %0d want 10", count); end
    #2 rst = 1'b1;
    #1;
    checks++; if (count !== 7'd0 || busy !== 1'b0 || full !== 1'b0 || ovf !== 1'b0 || r_do32 !== 32'd0) begin
      errors++; $display("FAIL rst_async count %0d busy %b full %b ovf %b rdata %h want all 0", count, busy, full, ovf, r_do32);
    end
    tick();
    rst = 1'b0;
    tick();
    pulse_go();
    checks++; if (count !== 7'd0 || busy !== 1'b1) begin errors++; $display("FAIL rst_restart count %0d busy %b want 0/1", count, busy); end
    done = 1'b1; result = 20'h77777; r_enb = 1'b1; r_addr = 6'd0;
    tick();
    done = 1'b0;
    checks++; if (r_do32 !== 32'h0000_0200) begin errors++; $display("FAIL rbw_old got %h want 00000200", r_do32); end
    tick();
    r_enb = 1'b0;
    checks++; if (r_do32 !== 32'h0007_7777) begin errors++; $display("FAIL rbw_new got %h want 00077777", r_do32); end
    checks++; if (count !== 7'd1) begin errors++; $display("FAIL rst_count1 got %0d want 1", count); end
  endtask

`ifdef FINAL_RB_CHECKSUM_EN
  task automatic test_checksum();
    pulse_go();
    checks++; if (chk !== 26'd0) begin errors++; $display("FAIL chk_clear got %0d want 0", chk); end
    for (int i = 1; i <= 64; i++) begin
      done = 1'b1; result = 20'(i);
      tick();
    end
    done = 1'b1; result = 20'h12345;
    tick();
    done = 1'b0;
    checks++; if (chk !== 26'd2080) begin errors++; $display("FAIL chk_sum got %0d want 2080", chk); end
  endtask
`endif

  initial begin
    rst = 1'b1; go = 1'b0; done = 1'b0; result = '0; r_enb = 1'b0; r_addr = '0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_spaced();
    test_back_to_back();
    test_overflow();
    test_go_drop();
    test_rst_midrun();
`ifdef FINAL_RB_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
